// File: rtl/serial_pkg.sv
// Shared encodings for the framed serial link: FSM state codes and line levels.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_shift_core.sv
// Direction-selectable WIDTH-bit deserialising shift register with synchronous clear.
module rx_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_msb_first,
    input  logic             i_sd,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            sr <= '0;
        end else if (i_shift) begin
            if (i_msb_first) sr <= {sr[WIDTH-2:0], i_sd};
            else             sr <= {i_sd, sr[WIDTH-1:1]};
        end
    end

    assign o_q = sr;

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start-bit hunt, WIDTH data bits, stop-bit check, one-cycle
// valid / frame-error strobes. Line is only looked at on cycles with i_en=1.
//
// state   | meaning
// ST_IDLE | line idle, hunting for a start bit
// ST_DATA | shifting in data bits, count = bits received so far
// ST_STOP | expecting the stop bit
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sd,
    input  logic             i_msb_first,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             dir_msb;
    logic [WIDTH-1:0] sr;
    logic             sr_clr;
    logic             sr_shift;

    // The start bit clears the shifter in the same edge the FSM enters ST_DATA.
    assign sr_clr   = i_rst | (i_en && state == ST_IDLE && i_sd == START_BIT);
    assign sr_shift = i_en && state == ST_DATA;

    rx_shift_core #(.WIDTH(WIDTH)) u_core (
        .i_clk       (i_clk),
        .i_clr       (sr_clr),
        .i_shift     (sr_shift),
        .i_msb_first (dir_msb),
        .i_sd        (i_sd),
        .o_q         (sr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dir_msb     <= 1'b0;
            o_q         <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            if (i_en) begin
                case (state)
                    ST_IDLE: begin
                        if (i_sd == START_BIT) begin
                            state   <= ST_DATA;
                            cnt     <= '0;
                            dir_msb <= i_msb_first;
                            o_busy  <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (i_sd == STOP_BIT) begin
                            o_q     <= sr;
                            o_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (WIDTH=4): directed frames queue their expected
// result; a negedge monitor pops and compares on every valid / frame-error strobe.
module tb_serial_frame_rx;

    localparam int W = 4;

    typedef struct {
        logic         is_err;
        logic [W-1:0] q;
    } exp_t;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_en = 1'b0;
    logic         i_sd = 1'b1;
    logic         i_msb_first = 1'b0;
    logic [W-1:0] o_q;
    logic         o_valid;
    logic         o_frame_err;
    logic         o_busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   valid_pulses = 0;
    int   busy_cycles = 0;

    serial_frame_rx #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_sd        (i_sd),
        .i_msb_first (i_msb_first),
        .o_q         (o_q),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (o_valid && o_frame_err) chk("valid_and_err_together", 1, 0);
        if (o_valid || o_frame_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind_err", int'(o_frame_err), int'(e.is_err));
                if (!e.is_err) chk("frame_word", int'(o_q), int'(e.q));
            end
        end
        if (o_valid) valid_pulses++;
        if (o_busy)  busy_cycles++;
    end

    task automatic tick(input logic en, input logic sd);
        @(posedge clk);
        #1;
        i_en = en;
        i_sd = sd;
    endtask

    // seq[0] is the first bit on the line (start bit); tog_at flips i_msb_first mid-frame.
    task automatic send_frame(input logic [0:5] seq, input logic msb, input int gap,
                              input int tog_at);
        for (int i = 0; i < 6; i++) begin
            for (int g = 1; g < gap; g++) tick(1'b0, (g % 2) == 1);
            tick(1'b1, seq[i]);
            if (i == 0) i_msb_first = msb;
            if (i == tog_at) i_msb_first = ~msb;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
    endtask

    task automatic push(input logic is_err, input logic [W-1:0] q);
        exp_t e;
        e.is_err = is_err;
        e.q      = q;
        exp_q.push_back(e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk("reset_q", int'(o_q), 0);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_err", int'(o_frame_err), 0);
        chk("reset_busy", int'(o_busy), 0);

        // 1: LSB-first, data 1,0,0,1 -> 1001
        busy_cycles = 0;
        push(1'b0, 4'b1001);
        i_msb_first = 1'b0;
        send_frame(6'b010011, 1'b0, 1, -1);
        idle(4);
        chk("t1_busy_cycles", busy_cycles, 5);

        // 2: MSB-first, data 0,1,1,0 -> 0110
        push(1'b0, 4'b0110);
        i_msb_first = 1'b1;
        send_frame(6'b001101, 1'b1, 1, -1);
        idle(4);

        // 3: stop bit 0 -> frame error, word kept
        push(1'b1, 4'b0000);
        i_msb_first = 1'b0;
        send_frame(6'b011110, 1'b0, 1, -1);
        idle(4);
        @(negedge clk);
        chk("t3_q_held", int'(o_q), 4'b0110);
        chk("t3_busy", int'(o_busy), 0);

        // 4: scenario 1 with enable every third cycle and line noise in between
        valid_pulses = 0;
        push(1'b0, 4'b1001);
        send_frame(6'b010011, 1'b0, 3, -1);
        idle(4);
        chk("t4_valid_pulses", valid_pulses, 1);

        // 5: reset after two data bits, then a clean frame
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        @(posedge clk);
        #1 i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        i_en = 1'b1;
        i_sd = 1'b1;
        @(negedge clk);
        chk("t5_busy_after_rst", int'(o_busy), 0);
        chk("t5_q_after_rst", int'(o_q), 0);
        idle(2);
        push(1'b0, 4'b1100);
        send_frame(6'b000111, 1'b0, 1, -1);
        idle(4);

        // 6: back-to-back; first frame MSB-first 1,0,1,1 -> 1011 with a mid-frame toggle,
        //    second frame LSB-first 0,1,1,1 -> 1110
        valid_pulses = 0;
        push(1'b0, 4'b1011);
        push(1'b0, 4'b1110);
        send_frame(6'b010111, 1'b1, 1, 2);
        send_frame(6'b001111, 1'b0, 1, -1);
        idle(5);
        chk("t6_valid_pulses", valid_pulses, 2);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial-to-parallel framed receiver: the receive end of the serial link driven by the team's universal shift register in serial-out mode.
- Hunts for a start bit and shifts in WIDTH data bits, LSB-first or MSB-first per frame.
- Checks the stop bit, then presents the word on a parallel bus with a one-cycle valid strobe.
- Sits between the serial line and downstream parallel logic; the bit rate is set by an external bit strobe.

Parameters:
WIDTH, 4, data bits per frame (legal range: WIDTH >= 2)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  reset, synchronous, active-high
i_en  input  1  bit strobe; line sampled only in cycles where i_en=1
i_sd  input  1  serial data line; idle level 1
i_msb_first  input  1  1: first data bit is MSB; 0: first data bit is LSB
o_q  output  WIDTH  last correctly framed word
o_valid  output  1  one-cycle pulse: o_q updated this cycle
o_frame_err  output  1  one-cycle pulse: stop bit was 0, word discarded
o_busy  output  1  frame in progress (DATA or STOP state)

Behaviour:
- Single clock i_clk. Reset is synchronous and active-high on i_rst, and has priority over all other inputs.
- Reset values: state=IDLE, bit count=0, shift reg=0, o_q=0, o_valid=0, o_frame_err=0, o_busy=0.
- Cycles with i_en=0:
  - state, count, shift reg and o_q hold.
  - o_valid and o_frame_err are 0.
  - i_sd is ignored.
- o_valid and o_frame_err are registered pulses. Each is high for exactly one cycle, the cycle after the edge that sampled the stop bit. They are never both high.
- FSM states: IDLE, DATA, STOP.
- IDLE:
  - i_en=1 and i_sd=0 (start bit): go to DATA; count<=0; shift reg<=0; latch i_msb_first as the frame direction.
  - i_en=1 and i_sd=1: stay in IDLE.
- DATA, on each i_en=1:
  - Shift i_sd in.
  - LSB-first: sr <= {i_sd, sr[WIDTH-1:1]}.
  - MSB-first: sr <= {sr[WIDTH-2:0], i_sd}.
  - count++. After the WIDTH-th data bit, go to STOP.
- STOP, on i_en=1:
  - i_sd=1: o_q<=sr; pulse o_valid.
  - i_sd=0: pulse o_frame_err; o_q unchanged.
  - Either case: go to IDLE.
- Back-to-back frames: a start bit on the very next i_en after the stop bit is accepted. There are no required idle bits.
- i_msb_first changes mid-frame are ignored; it is sampled only at the start bit.
- o_busy=1 whenever state is DATA or STOP. It is a registered state decode.
- Reset mid-frame: abort to IDLE, o_q=0, no valid or error pulse.
- Frame length on the line is WIDTH+2 enabled cycles. o_q is stable except in the o_valid cycle.
- Bit count is $clog2(WIDTH+1) bits wide. Count never wraps; the terminal compare is count==WIDTH-1 on the shifting strobe.

Decomposition:
- Shared package/header serial_pkg:
  - state encodings ST_IDLE=2'd0, ST_DATA=2'd1, ST_STOP=2'd2.
  - line levels LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, rx_shift_core:
  - WIDTH-bit direction-selectable shift register.
  - Inputs: clear, shift enable, direction, serial in. Output: parallel word.
  - Synchronous active-high clear.
- FSM, counter and output registers live in serial_frame_rx.

Test Plan:
All scenarios use WIDTH=4 and i_en=1 every cycle unless stated.
1. Reset, then LSB-first frame with line sequence 0,1,0,0,1,1 -> o_q=4'b1001; o_valid high one cycle; o_busy high for 5 cycles; o_frame_err=0.
2. MSB-first frame with line sequence 0,0,1,1,0,1 -> o_q=4'b0110; o_valid pulse.
3. Frame error: line sequence 0,1,1,1,1,0 -> o_frame_err one-cycle pulse; o_valid=0; o_q stays 4'b0110; returns to IDLE with o_busy=0.
4. Strobe gaps: repeat scenario 1 with i_en high every 3rd cycle, and i_sd toggling on i_en=0 cycles -> identical o_q=4'b1001, single o_valid pulse.
5. Reset mid-frame:
   - Assert i_rst after 2 data bits -> next cycle o_busy=0, o_q=4'b0000, no pulses.
   - Then an LSB-first frame with line sequence 0,0,0,1,1,1 -> o_q=4'b1100.
6. Back-to-back and direction hold:
   - Two frames with no idle gap; toggle i_msb_first mid-frame on the first.
   - First frame decodes in its start-bit direction; second decodes correctly.
   - Exactly two o_valid pulses.
